// File: rtl/bin2bcd_dabble_ctrl.sv
// Sequential shift-and-add-3 binary-to-BCD converter with start/busy/done handshake.
// Optional BIN2BCD_FAST_EN merges the correction and shift steps into one cycle per bit.
module bin2bcd_dabble_ctrl #(
  parameter int unsigned W      = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [W-1:0]          bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned RW = BW + W;
  localparam int unsigned CW = $clog2(W + 1);

`ifdef BIN2BCD_FAST_EN
  typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, ADJ, SHIFT, DONE} state_t;
`endif

  state_t          state_q, state_d;
  logic [RW-1:0]   work_q, work_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            flag_q, flag_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            ovf_q, ovf_d;
  logic            done_q, done_d;
  logic [RW-1:0]   work_adj;

  // Per-digit plus-three correction; digits are independent, no carry between them.
  function automatic logic [RW-1:0] add3(input logic [RW-1:0] r);
    logic [RW-1:0] o;
    logic [3:0]    dig;
    o = r;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      dig = r[W + 4*d +: 4];
      if (dig >= 4'd5) o[W + 4*d +: 4] = dig + 4'd3;
    end
    return o;
  endfunction

  assign work_adj = add3(work_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    flag_d  = flag_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        // Result registers and the done pulse update on the edge that leaves DONE,
        // so a back-to-back start still publishes the finished result.
        if (state_q == DONE) begin
          bcd_d  = work_q[RW-1:W];
          ovf_d  = flag_q;
          done_d = 1'b1;
        end
        state_d = IDLE;
        if (start) begin
          work_d         = '0;
          work_d[W-1:0]  = bin_in;
          cnt_d          = '0;
          flag_d         = 1'b0;
`ifdef BIN2BCD_FAST_EN
          state_d        = STEP;
`else
          state_d        = ADJ;
`endif
        end
      end
`ifdef BIN2BCD_FAST_EN
      STEP: begin
        flag_d  = flag_q | work_adj[RW-1];
        work_d  = {work_adj[RW-2:0], 1'b0};
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(W - 1)) ? DONE : STEP;
      end
`else
      ADJ: begin
        work_d  = work_adj;
        state_d = SHIFT;
      end
      SHIFT: begin
        flag_d  = flag_q | work_q[RW-1];
        work_d  = {work_q[RW-2:0], 1'b0};
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(W - 1)) ? DONE : ADJ;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

`ifdef BIN2BCD_FAST_EN
  assign busy = (state_q == STEP);
`else
  assign busy = (state_q == ADJ) || (state_q == SHIFT);
`endif
  assign done    = done_q;
  assign bcd_out = bcd_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_bin2bcd_dabble_ctrl.sv
// Directed and sweep bench for bin2bcd_dabble_ctrl: a 3-digit and a 2-digit instance share stimulus.
module tb_bin2bcd_dabble_ctrl;

`ifdef BIN2BCD_FAST_EN
  localparam int LAT = 9;
`else
  localparam int LAT = 17;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  bin_in = '0;
  logic        busy3, done3, ovf3;
  logic [11:0] bcd3;
  logic        busy2, done2, ovf2;
  logic [7:0]  bcd2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bin2bcd_dabble_ctrl #(.W(8), .DIGITS(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .busy(busy3), .done(done3), .bcd_out(bcd3), .ovf(ovf3)
  );

  bin2bcd_dabble_ctrl #(.W(8), .DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .busy(busy2), .done(done2), .bcd_out(bcd2), .ovf(ovf2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] dec3(input int v);
    return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [7:0] dec2(input int v);
    return {4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // One start pulse; returns edges from accepting edge to done (-1 on timeout).
  task automatic convert(input logic [7:0] v, output int lat);
    @(negedge clk);
    start  = 1'b1;
    bin_in = v;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (done3) begin
        lat = n;
        break;
      end
    end
  endtask

  typedef struct {
    logic [7:0]  v;
    logic [11:0] b3;
    logic        o3;
    logic [7:0]  b2;
    logic        o2;
  } vec_t;

  vec_t vecs[8] = '{
    '{8'd255, 12'h255, 1'b0, 8'h55, 1'b1},
    '{8'd0,   12'h000, 1'b0, 8'h00, 1'b0},
    '{8'd99,  12'h099, 1'b0, 8'h99, 1'b0},
    '{8'd100, 12'h100, 1'b0, 8'h00, 1'b1},
    '{8'd42,  12'h042, 1'b0, 8'h42, 1'b0},
    '{8'd9,   12'h009, 1'b0, 8'h09, 1'b0},
    '{8'd10,  12'h010, 1'b0, 8'h10, 1'b0},
    '{8'd199, 12'h199, 1'b0, 8'h99, 1'b1}
  };

  function automatic logic [7:0] hold_val(input int i);
    return 8'((i * 37 + 11) % 256);
  endfunction

  initial begin
    int lat;
    int pulses;
    int src;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", busy3, 1'b0);
    check_eq("rst_done", done3, 1'b0);
    check_eq("rst_bcd3", bcd3, 12'h000);
    check_eq("rst_ovf3", ovf3, 1'b0);
    check_eq("rst_bcd2", bcd2, 8'h00);
    @(negedge clk) rst = 1'b0;

    // Directed vectors
    foreach (vecs[i]) begin
      convert(vecs[i].v, lat);
      check_eq($sformatf("lat_%0d", vecs[i].v), lat, LAT);
      check_eq($sformatf("busy_at_done_%0d", vecs[i].v), busy3, 1'b0);
      check_eq($sformatf("bcd3_%0d", vecs[i].v), bcd3, vecs[i].b3);
      check_eq($sformatf("ovf3_%0d", vecs[i].v), ovf3, vecs[i].o3);
      check_eq($sformatf("done2_%0d", vecs[i].v), done2, 1'b1);
      check_eq($sformatf("bcd2_%0d", vecs[i].v), bcd2, vecs[i].b2);
      check_eq($sformatf("ovf2_%0d", vecs[i].v), ovf2, vecs[i].o2);
      @(posedge clk);
      #1;
      check_eq($sformatf("done_single_%0d", vecs[i].v), done3, 1'b0);
      check_eq($sformatf("busy_after_%0d", vecs[i].v), busy3, 1'b0);
      check_eq($sformatf("hold_bcd3_%0d", vecs[i].v), bcd3, vecs[i].b3);
    end

    // start held high, operand changing every cycle: accepted at edges 0, LAT, 2*LAT
    for (int i = 0; i <= 3 * LAT; i++) begin
      @(negedge clk);
      start  = (i < 3 * LAT);
      bin_in = hold_val(i);
      @(posedge clk);
      #1;
      check_eq($sformatf("hold_done_e%0d", i), done3, (i > 0) && (i % LAT == 0));
      if (done3) begin
        src = i - LAT;
        check_eq($sformatf("hold_bcd3_e%0d", i), bcd3, dec3(int'(hold_val(src))));
        check_eq($sformatf("hold_bcd2_e%0d", i), bcd2, dec2(int'(hold_val(src))));
      end
    end
    @(negedge clk) start = 1'b0;
    @(posedge clk);
    #1;
    check_eq("hold_busy_end", busy3, 1'b0);

    // Reset in the middle of a conversion of 200
    @(negedge clk);
    start  = 1'b1;
    bin_in = 8'd200;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_busy", busy3, 1'b0);
    check_eq("midrst_done", done3, 1'b0);
    check_eq("midrst_bcd3", bcd3, 12'h000);
    check_eq("midrst_ovf2", ovf2, 1'b0);
    check_eq("midrst_bcd2", bcd2, 8'h00);
    @(negedge clk) rst = 1'b0;
    pulses = 0;
    for (int n = 0; n < 2 * LAT + 4; n++) begin
      @(posedge clk);
      #1;
      if (done3 || busy3) pulses++;
    end
    check_eq("midrst_no_activity", pulses, 0);
    convert(8'd42, lat);
    check_eq("post_rst_lat", lat, LAT);
    check_eq("post_rst_bcd3", bcd3, 12'h042);

    // Full operand sweep against a decimal reference
    for (int v = 0; v < 256; v++) begin
      convert(8'(v), lat);
      check_eq($sformatf("sweep_lat_%0d", v), lat, LAT);
      check_eq($sformatf("sweep_bcd3_%0d", v), bcd3, dec3(v));
      check_eq($sformatf("sweep_ovf3_%0d", v), ovf3, 1'b0);
      check_eq($sformatf("sweep_bcd2_%0d", v), bcd2, dec2(v));
      check_eq($sformatf("sweep_ovf2_%0d", v), ovf2, v >= 100);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
